// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program-counter unit for the Mano-style CPU.
//
// Owns the PC register and decides each cycle whether to clear, load or
// increment it from the timing signals, decoded opcode and skip conditions.
// Optional branch-trace FIFO records non-sequential PC changes.
//
// Build option: define PC_TRACE_EN to implement the trace FIFO; without it
// trace_valid/trace_data/trace_ovf are tied to 0 and trace_ready is ignored.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 freeze PC and trace push this cycle
//   t, d                  one-hot timing T0..T7 and decoded opcode D0..D7
//   i, r                  IR[15] indirect bit, interrupt-cycle flip-flop
//   ir_b, dr, ac          IR low bits, data register, accumulator
//   e, fgi, fgo           E flag, input/output flags
//   ar                    PC load source
//   pc                    program counter
//   pc_clr/pc_inr/pc_load action taken this cycle (combinational)
//   skip                  increment caused by a skip condition
//   trace_valid/ready     trace FIFO pop handshake
//   trace_data            {cause[1:0], from_pc}; 0=skip 1=BUN 2=BSA 3=interrupt
//   trace_ovf             sticky, a trace entry was dropped
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int INT_BASE    = 0,
    parameter int TRACE_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [7:0]        t,
    input  logic [7:0]        d,
    input  logic              i,
    input  logic              r,
    input  logic [DATA_W-1:0] ir_b,
    input  logic [DATA_W-1:0] dr,
    input  logic [DATA_W-1:0] ac,
    input  logic              e,
    input  logic              fgi,
    input  logic              fgo,
    input  logic [ADDR_W-1:0] ar,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_clr,
    output logic              pc_inr,
    output logic              pc_load,
    output logic              skip,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [ADDR_W+1:0] trace_data,
    output logic              trace_ovf
);

    logic [ADDR_W-1:0] pc_reg;

    logic clr_req, load_req, seq_inc, isz_skip, reg_skip, io_skip, skip_req;

    // Raw requests, before priority and stall gating
    assign clr_req  = r & t[1];
    assign load_req = (d[4] & t[4]) | (d[5] & t[5]);
    assign seq_inc  = (~r & t[1]) | (r & t[2]);
    assign isz_skip = d[6] & t[6] & (dr == '0);
    assign reg_skip = d[7] & ~i & t[3] &
                      ((ir_b[4] & ~ac[DATA_W-1]) |
                       (ir_b[3] &  ac[DATA_W-1]) |
                       (ir_b[2] & (ac == '0))    |
                       (ir_b[1] & ~e));
    assign io_skip  = d[7] & i & t[3] & ((ir_b[9] & fgi) | (ir_b[8] & fgo));
    assign skip_req = isz_skip | reg_skip | io_skip;

    // clear > load > increment; only the winner's strobe is raised
    assign pc_clr  = ~stall & clr_req;
    assign pc_load = ~stall & ~clr_req & load_req;
    assign pc_inr  = ~stall & ~clr_req & ~load_req & (seq_inc | skip_req);
    assign skip    = pc_inr & skip_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= '0;
        end else if (pc_clr) begin
            pc_reg <= ADDR_W'(INT_BASE);
        end else if (pc_load) begin
            pc_reg <= ar;
        end else if (pc_inr) begin
            pc_reg <= pc_reg + 1'b1;   // wraps silently
        end
    end

    assign pc = pc_reg;

`ifdef PC_TRACE_EN
    localparam int PW = $clog2(TRACE_DEPTH);
    localparam int TW = ADDR_W + 2;

    logic [TW-1:0] trace_mem [TRACE_DEPTH];
    logic [PW:0]   wr_ptr_reg, rd_ptr_reg;   // extra MSB distinguishes full/empty
    logic          ovf_reg;
    logic          fifo_empty, fifo_full, push, pop, push_ok;
    logic [1:0]    cause;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                        (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);

    // Strobes already carry the stall gating, so a stalled cycle never pushes
    assign push    = pc_clr | pc_load | skip;
    assign pop     = ~fifo_empty & trace_ready;
    // A pop on the same edge frees the slot the push lands in
    assign push_ok = push & (~fifo_full | pop);

    assign cause = pc_clr  ? 2'd3 :
                   pc_load ? ((d[4] & t[4]) ? 2'd1 : 2'd2) :
                             2'd0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            trace_mem[wr_ptr_reg[PW-1:0]] <= {cause, pc_reg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push & ~push_ok) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign trace_valid = ~fifo_empty;
    // Forced to 0 when empty so stale or uninitialised storage never leaks out
    assign trace_data  = fifo_empty ? '0 : trace_mem[rd_ptr_reg[PW-1:0]];
    assign trace_ovf   = ovf_reg;

    logic unused_ok;
    assign unused_ok = &{1'b0, ir_b[DATA_W-1:10], ir_b[7:5], ir_b[0], d[3:0], t[7], t[0]};
`else
    assign trace_valid = 1'b0;
    assign trace_data  = '0;
    assign trace_ovf   = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, ir_b[DATA_W-1:10], ir_b[7:5], ir_b[0], d[3:0], t[7], t[0],
                         trace_ready};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- directed self-checking bench for pc_unit.
// PC behaviour is checked in every build; trace FIFO contents are expected
// only when PC_TRACE_EN is defined, otherwise the trace outputs must read 0.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    localparam int AW = 12;
    localparam int DW = 16;
`ifdef PC_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic [7:0]    t = '0;
    logic [7:0]    d = '0;
    logic          i = 1'b0;
    logic          r = 1'b0;
    logic [DW-1:0] ir_b = '0;
    logic [DW-1:0] dr = '0;
    logic [DW-1:0] ac = '0;
    logic          e = 1'b0;
    logic          fgi = 1'b0;
    logic          fgo = 1'b0;
    logic [AW-1:0] ar = '0;
    logic [AW-1:0] pc;
    logic          pc_clr, pc_inr, pc_load, skip;
    logic          trace_valid;
    logic          trace_ready = 1'b1;
    logic [AW+1:0] trace_data;
    logic          trace_ovf;

    int errors = 0;
    int checks = 0;

    pc_unit #(.ADDR_W(AW), .DATA_W(DW), .INT_BASE(0), .TRACE_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .t(t), .d(d), .i(i), .r(r),
        .ir_b(ir_b), .dr(dr), .ac(ac), .e(e), .fgi(fgi), .fgo(fgo), .ar(ar),
        .pc(pc), .pc_clr(pc_clr), .pc_inr(pc_inr), .pc_load(pc_load), .skip(skip),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_data(trace_data), .trace_ovf(trace_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle();
        t = '0; d = '0; r = 1'b0; i = 1'b0; stall = 1'b0;
        ir_b = '0; dr = 16'h00FF; ac = 16'h0001; e = 1'b1; fgi = 1'b0; fgo = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bun(input logic [AW-1:0] a);
        idle(); d = 8'h10; t = 8'h10; ar = a;
        tick();
        idle();
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    logic [AW+1:0] exp_q [8];

    initial begin
        idle();
        #12;
        check("reset_pc", pc, 0);
        check("reset_valid", trace_valid, 0);
        check("reset_data", trace_data, 0);
        check("reset_ovf", trace_ovf, 0);
        @(negedge clk) rst_n = 1'b1;

        // BUN to 0x005
        d = 8'h10; t = 8'h10; ar = 12'h005; #1;
        check("bun_load_strobe", pc_load, 1);
        check("bun_inr_strobe", pc_inr, 0);
        tick(); idle();
        check("bun_pc", pc, 12'h005);
        check("bun_trace_valid", trace_valid, TR);
        check("bun_trace_data", trace_data, TR ? 14'h1000 : 14'h0);

        // Fetch increment, not traced
        t = 8'h02; #1;
        check("fetch_inr", pc_inr, 1);
        check("fetch_skip", skip, 0);
        tick(); idle();
        check("fetch_pc", pc, 12'h006);
        check("fetch_no_trace", trace_valid, 0);

        // Wrap
        bun(12'hFFF);
        check("wrap_bun_trace", trace_data, TR ? 14'h1006 : 14'h0);
        t = 8'h02; tick(); idle();
        check("wrap_pc", pc, 12'h000);

        // Interrupt: r.T1 then r.T2
        bun(12'h123);
        r = 1'b1; t = 8'h02; #1;
        check("intr_clr_strobe", pc_clr, 1);
        tick(); idle();
        check("intr_pc_clr", pc, 12'h000);
        check("intr_trace_data", trace_data, TR ? 14'h3123 : 14'h0);
        r = 1'b1; t = 8'h04; #1;
        check("intr_t2_inr", pc_inr, 1);
        check("intr_t2_skip", skip, 0);
        tick(); idle();
        check("intr_t2_pc", pc, 12'h001);
        check("intr_t2_trace_empty", trace_valid, 0);

        // SZA with ac=0, then ac=1
        d = 8'h80; t = 8'h08; ir_b = 16'h0004; ac = 16'h0000; #1;
        check("sza_skip", skip, 1);
        tick(); idle();
        check("sza_pc", pc, 12'h002);
        check("sza_trace", trace_data, TR ? 14'h0001 : 14'h0);
        d = 8'h80; t = 8'h08; ir_b = 16'h0004; ac = 16'h0001; #1;
        check("sza_nz_inr", pc_inr, 0);
        check("sza_nz_skip", skip, 0);
        tick(); idle();
        check("sza_nz_pc", pc, 12'h002);

        // SKI with fgi=1
        d = 8'h80; t = 8'h08; i = 1'b1; ir_b = 16'h0200; fgi = 1'b1; #1;
        check("ski_skip", skip, 1);
        tick(); idle();
        check("ski_pc", pc, 12'h003);
        check("ski_trace", trace_data, TR ? 14'h0002 : 14'h0);

        // ISZ with dr=0, then dr=1
        d = 8'h40; t = 8'h40; dr = 16'h0000; tick(); idle();
        check("isz_zero_pc", pc, 12'h004);
        d = 8'h40; t = 8'h40; dr = 16'h0001; #1;
        check("isz_nz_inr", pc_inr, 0);
        tick(); idle();
        check("isz_nz_pc", pc, 12'h004);

        // Priority: r.T1 together with D4.T4
        r = 1'b1; t = 8'h12; d = 8'h10; ar = 12'h2A0; #1;
        check("prio_clr", pc_clr, 1);
        check("prio_load", pc_load, 0);
        check("prio_inr", pc_inr, 0);
        tick(); idle();
        check("prio_pc", pc, 12'h000);
        check("prio_trace", trace_data, TR ? 14'h3004 : 14'h0);
        bun(12'h2A0);
        check("bun2a0_pc", pc, 12'h2A0);
        check("bun2a0_trace", trace_data, TR ? 14'h1000 : 14'h0);

        // Stall during fetch: PC held, strobes 0, pop still proceeds
        stall = 1'b1; t = 8'h02; #1;
        check("stall_inr", pc_inr, 0);
        check("stall_clr", pc_clr, 0);
        tick(); idle();
        check("stall_pc", pc, 12'h2A0);
        check("stall_pop", trace_valid, 0);

`ifdef PC_TRACE_EN
        // Overflow: 9 BUNs, no pop
        pulse_reset();
        trace_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bun(12'(12'h010 + k));
            if (k == 7) check("ovf_full_no_ovf", trace_ovf, 0);
        end
        check("ovf_set", trace_ovf, 1);
        check("ovf_head", trace_data, 14'h1000);
        tick(); tick();
        check("ovf_head_stable", trace_data, 14'h1000);
        // Full with simultaneous pop and push
        trace_ready = 1'b1;
        bun(12'h050);
        check("pushpop_pc", pc, 12'h050);
        check("pushpop_ovf", trace_ovf, 1);
        for (int j = 0; j < 7; j++) exp_q[j] = 14'(14'h1010 + j);
        exp_q[7] = 14'h1018;
        for (int j = 0; j < 8; j++) begin
            check($sformatf("drain_valid%0d", j), trace_valid, 1);
            check($sformatf("drain_data%0d", j), trace_data, exp_q[j]);
            tick();
        end
        check("drain_empty", trace_valid, 0);
`else
        trace_ready = 1'b0;
        for (int k = 0; k < 9; k++) bun(12'(12'h010 + k));
        check("notrace_valid", trace_valid, 0);
        check("notrace_ovf", trace_ovf, 0);
        check("notrace_pc", pc, 12'h018);
`endif

        // Asynchronous reset mid-burst
        trace_ready = 1'b0;
        bun(12'h100);
        bun(12'h200);
        check("burst_pc", pc, 12'h200);
        check("burst_valid", trace_valid, TR);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 0);
        check("async_rst_valid", trace_valid, 0);
        check("async_rst_ovf", trace_ovf, 0);
        @(negedge clk) rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
